// File: rtl/hc_sr04_emulator.sv
// hc_sr04_emulator: bus-mapped stand-in for an HC-SR04 ultrasonic sensor (trigger in, echo out).
// Define HC_SR04_EMU_NOISE_EN to add 0..7 ticks of LFSR jitter to each echo width.
module hc_sr04_emulator #(
    parameter int TRIG_MIN_CYC = 500,
    parameter int BURST_CYC    = 10000,
    parameter int TICK_DIV     = 1,
    parameter int TIMEOUT_CYC  = 1900000,
    parameter int HOLDOFF_CYC  = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    input  logic        trigger,
    output logic        echo
);

    localparam logic [4:0]  ADDR_WIDTH     = 5'h00;
    localparam logic [4:0]  ADDR_CONTROL   = 5'h04;
    localparam logic [4:0]  ADDR_STATUS    = 5'h08;
    localparam logic [4:0]  ADDR_LAST_TRIG = 5'h0C;

    localparam logic [31:0] TRIG_MIN     = 32'(TRIG_MIN_CYC);
    localparam logic [31:0] BURST_LAST   = 32'(BURST_CYC - 1);
    localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYC - 1);
    localparam logic [31:0] TIMEOUT      = 32'(TIMEOUT_CYC);
    localparam logic [31:0] TICK         = 32'(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    state_t      state, state_next;
    logic        trig_meta, trig_s;
    logic [15:0] width_reg;
    logic        enable, no_echo;
    logic [31:0] cnt, cnt_next;
    logic        echo_next;
    logic [31:0] last_trig, last_trig_next;
    logic [7:0]  reject_cnt, reject_next;
    logic [15:0] meas_cnt, meas_next;
    logic [15:0] width_latched, width_latched_next;
    logic [31:0] echo_len, echo_len_next;
    logic [31:0] echo_len_calc;
    logic [31:0] ticks;
    logic [31:0] scaled;
    logic        accept;
    logic        unused_bus;

    assign unused_bus = ^d_in[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
        end else begin
            trig_meta <= trigger;
            trig_s    <= trig_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_reg <= 16'h5A00;
            enable    <= 1'b1;
            no_echo   <= 1'b0;
        end else if (cs && wr) begin
            case (addr)
                ADDR_WIDTH:   width_reg <= d_in[15:0];
                ADDR_CONTROL: begin
                    enable  <= d_in[0];
                    no_echo <= d_in[1];
                end
                default: ;
            endcase
        end
    end

`ifdef HC_SR04_EMU_NOISE_EN
    logic [15:0] lfsr;
    logic [2:0]  jitter;

    // Jitter is captured alongside width_latched so the pulse length is fixed at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= 16'hACE1;
            jitter <= 3'd0;
        end else if (accept) begin
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            jitter <= lfsr[2:0];
        end
    end

    assign ticks = {16'd0, width_latched} + {29'd0, jitter};
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign ticks = {16'd0, width_latched};
`endif

    assign scaled = ticks * TICK;

    always_comb begin
        echo_len_calc = scaled;
        if (width_latched == 16'd0 || no_echo) begin
            echo_len_calc = TIMEOUT;
        end else if (scaled > TIMEOUT) begin
            echo_len_calc = TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            echo          <= 1'b0;
            last_trig     <= '0;
            reject_cnt    <= '0;
            meas_cnt      <= '0;
            width_latched <= '0;
            echo_len      <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            echo          <= echo_next;
            last_trig     <= last_trig_next;
            reject_cnt    <= reject_next;
            meas_cnt      <= meas_next;
            width_latched <= width_latched_next;
            echo_len      <= echo_len_next;
        end
    end

    // A single shared cycle counter times every state; it is cleared on each state change.
    always_comb begin
        state_next         = state;
        cnt_next           = cnt;
        echo_next          = echo;
        last_trig_next     = last_trig;
        reject_next        = reject_cnt;
        meas_next          = meas_cnt;
        width_latched_next = width_latched;
        echo_len_next      = echo_len;
        accept             = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            echo_next  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig_s) begin
                        state_next = TRIG_HI;
                        cnt_next   = 32'd1;
                    end
                end
                TRIG_HI: begin
                    if (trig_s) begin
                        if (cnt != '1) cnt_next = cnt + 32'd1;
                    end else begin
                        last_trig_next = cnt;
                        cnt_next       = '0;
                        if (cnt >= TRIG_MIN) begin
                            state_next         = BURST;
                            width_latched_next = width_reg;
                            accept             = 1'b1;
                        end else begin
                            state_next = IDLE;
                            if (reject_cnt != 8'hFF) reject_next = reject_cnt + 8'd1;
                        end
                    end
                end
                BURST: begin
                    if (cnt == BURST_LAST) begin
                        state_next    = ECHO;
                        echo_next     = 1'b1;
                        cnt_next      = '0;
                        echo_len_next = echo_len_calc;
                    end else begin
                        cnt_next = cnt + 32'd1;
                    end
                end
                ECHO: begin
                    if (cnt == echo_len - 32'd1) begin
                        state_next = HOLDOFF;
                        echo_next  = 1'b0;
                        cnt_next   = '0;
                        meas_next  = meas_cnt + 16'd1;
                    end else begin
                        cnt_next = cnt + 32'd1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLDOFF_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 32'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    echo_next  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        d_out = '0;
        if (cs && rd) begin
            case (addr)
                ADDR_WIDTH:     d_out = {16'd0, width_reg};
                ADDR_CONTROL:   d_out = {30'd0, no_echo, enable};
                ADDR_STATUS:    d_out = {meas_cnt, reject_cnt, 5'd0, state};
                ADDR_LAST_TRIG: d_out = last_trig;
                default:        d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hc_sr04_emulator.sv
// tb_hc_sr04_emulator: scoreboard bench; stimulus queues expected reads/echo pulses, a monitor checks them.
module tb_hc_sr04_emulator;

    localparam int TRIG_MIN_CYC = 10;
    localparam int BURST_CYC    = 20;
    localparam int TICK_DIV     = 4;
    localparam int TIMEOUT_CYC  = 1000;
    localparam int HOLDOFF_CYC  = 50;
    // trigger drop -> two synchronizer stages -> one cycle to leave TRIG_HI -> burst
    localparam int ECHO_DELAY   = BURST_CYC + 3;

    localparam logic [4:0] A_WIDTH = 5'h00;
    localparam logic [4:0] A_CTRL  = 5'h04;
    localparam logic [4:0] A_STAT  = 5'h08;
    localparam logic [4:0] A_LAST  = 5'h0C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d_in = '0;
    logic        cs = 1'b0;
    logic [4:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] d_out;
    logic        trigger = 1'b0;
    logic        echo;

    hc_sr04_emulator #(
        .TRIG_MIN_CYC(TRIG_MIN_CYC),
        .BURST_CYC(BURST_CYC),
        .TICK_DIV(TICK_DIV),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .HOLDOFF_CYC(HOLDOFF_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .d_in(d_in),
        .cs(cs),
        .addr(addr),
        .rd(rd),
        .wr(wr),
        .d_out(d_out),
        .trigger(trigger),
        .echo(echo)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isEcho;
        string       name;
        logic [31:0] value;
    } expect_t;

    expect_t sbQueue[$];
    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;
    int trigDropCycle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic pushExpect(input bit isEcho, input string name, input logic [31:0] value);
        expect_t e;
        e.isEcho = isEcho;
        e.name   = name;
        e.value  = value;
        sbQueue.push_back(e);
    endtask

    task automatic popCompare(input bit isEcho, input logic [31:0] actual, input string what);
        expect_t e;
        if (sbQueue.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_%s: got 0x%08h, expected no output", what, actual);
        end else begin
            e = sbQueue.pop_front();
            if (e.isEcho != isEcho) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL order_%s: got %s event, expected %s", e.name,
                         isEcho ? "echo" : "read", e.isEcho ? "echo" : "read");
            end else begin
                checkOutput(e.name, actual, e.value);
            end
        end
    endtask

    // Monitor: compares every bus read and every completed echo pulse against the queue head.
    logic echoPrev = 1'b0;
    int   echoWidth = 0;
    int   echoDelay = 0;

    always @(negedge clk) begin
        if (cs && rd) popCompare(1'b0, d_out, "read");
        if (echo && !echoPrev) begin
            echoDelay <= cyc - trigDropCycle;
            echoWidth <= 1;
        end else if (echo) begin
            echoWidth <= echoWidth + 1;
        end else if (echoPrev) begin
            popCompare(1'b1, echoDelay, "echo_delay");
            popCompare(1'b1, echoWidth, "echo_width");
        end
        echoPrev <= echo;
    end

    // All tasks below start and end 1 ns after a rising edge.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int highCycles);
        trigger = 1'b1;
        waitCycles(highCycles);
        trigger = 1'b0;
        trigDropCycle = cyc;
    endtask

    task automatic busWrite(input logic [4:0] a, input logic [31:0] data);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
        waitCycles(1);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic busRead(input logic [4:0] a, input logic [31:0] expected, input string name);
        pushExpect(1'b0, name, expected);
        cs = 1'b1; rd = 1'b1; addr = a;
        waitCycles(1);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic expectEcho(input int width, input string name);
        pushExpect(1'b1, {name, "_delay"}, ECHO_DELAY);
        pushExpect(1'b1, {name, "_width"}, width);
    endtask

    task automatic waitLevel(input logic level, input int bound, input string name);
        int n = 0;
        while (echo !== level && n < bound) begin
            waitCycles(1);
            n++;
        end
        if (echo !== level) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: echo still %b after %0d cycles, expected %b", name, echo, bound, level);
        end
    endtask

    task automatic runEcho(input string name);
        waitLevel(1'b1, ECHO_DELAY + 50, {name, "_rise_timeout"});
        waitLevel(1'b0, TIMEOUT_CYC + 100, {name, "_fall_timeout"});
        waitCycles(HOLDOFF_CYC + 10);
    endtask

    task automatic doReset();
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        waitCycles(3);
        rst = 1'b0;

        checkOutput("echo_reset", {31'd0, echo}, 32'd0);
        checkOutput("d_out_idle", d_out, 32'd0);
        busRead(A_WIDTH, 32'h0000_5A00, "width_reset");
        busRead(A_CTRL,  32'h0000_0001, "control_reset");
        busRead(A_STAT,  32'h0000_0000, "status_reset");
        busRead(A_LAST,  32'h0000_0000, "last_trig_reset");
        busRead(5'h10,   32'h0000_0000, "unmapped_read");

        // WIDTH=25 -> 25*4 = 100 cycle echo
        busWrite(A_WIDTH, 32'd25);
        expectEcho(100, "echo_w25");
        applyStimulus(12);
        runEcho("echo_w25");
        busRead(A_STAT, 32'h0001_0000, "status_after_first");
        busRead(A_LAST, 32'd12, "last_trig_12");

        // too-short trigger is rejected
        applyStimulus(5);
        waitCycles(10);
        busRead(A_STAT, 32'h0001_0100, "status_reject");
        busRead(A_LAST, 32'd5, "last_trig_5");

        // WIDTH=0 and WIDTH=FFFF both give the timeout width
        busWrite(A_WIDTH, 32'd0);
        expectEcho(TIMEOUT_CYC, "echo_w0");
        applyStimulus(12);
        runEcho("echo_w0");
        busWrite(A_WIDTH, 32'h0000_FFFF);
        expectEcho(TIMEOUT_CYC, "echo_wmax");
        applyStimulus(12);
        runEcho("echo_wmax");

        // no_echo forces the timeout width
        busWrite(A_WIDTH, 32'd25);
        busWrite(A_CTRL, 32'd3);
        expectEcho(TIMEOUT_CYC, "echo_noecho");
        applyStimulus(12);
        runEcho("echo_noecho");
        busWrite(A_CTRL, 32'd1);
        busRead(A_STAT, 32'h0004_0100, "status_four_meas");

        // fresh start: retriggers during ECHO and HOLDOFF are ignored
        doReset();
        busRead(A_STAT, 32'h0000_0000, "status_after_rst");
        busRead(A_WIDTH, 32'h0000_5A00, "width_after_rst");
        busWrite(A_WIDTH, 32'd25);
        expectEcho(100, "echo_retrig");
        applyStimulus(12);
        waitLevel(1'b1, ECHO_DELAY + 50, "echo_retrig_rise_timeout");
        waitCycles(10);
        applyStimulus(15);
        waitLevel(1'b0, TIMEOUT_CYC + 100, "echo_retrig_fall_timeout");
        waitCycles(5);
        applyStimulus(15);
        waitCycles(HOLDOFF_CYC + 10);
        busRead(A_STAT, 32'h0001_0000, "status_retrig");

        // disable mid-echo: write lands 31 cycles after rise, echo drops one cycle later
        expectEcho(32, "echo_abort");
        applyStimulus(12);
        waitLevel(1'b1, ECHO_DELAY + 50, "echo_abort_rise_timeout");
        waitCycles(30);
        busWrite(A_CTRL, 32'd0);
        waitCycles(2);
        busRead(A_STAT, 32'h0001_0000, "status_abort");
        busWrite(A_CTRL, 32'd1);
        expectEcho(100, "echo_reenable");
        applyStimulus(12);
        runEcho("echo_reenable");

        // WIDTH change during BURST applies to the following measurement
        expectEcho(100, "echo_old_width");
        applyStimulus(12);
        waitCycles(10);
        busWrite(A_WIDTH, 32'd50);
        runEcho("echo_old_width");
        expectEcho(200, "echo_new_width");
        applyStimulus(12);
        runEcho("echo_new_width");
        busRead(A_STAT, 32'h0004_0000, "status_final");
        busRead(A_LAST, 32'd12, "last_trig_final");

        waitCycles(5);
        checkOutput("scoreboard_drained", sbQueue.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/hc_sr04_emulator.md
Name: hc_sr04_emulator

Overview:
- Bus-mapped responder that stands in for a physical HC-SR04 ultrasonic module.
- Watches the trigger line driven by the sensor controller and answers with an echo pulse whose width the CPU programs as a simulated distance.
- Used on the FPGA for hardware-in-the-loop testing of the irrigation controller without a real sensor or water tank.
- Sits on the same peripheral bus as the other cores; its trigger/echo pins are looped to the controller's pins.

Parameters:
- TRIG_MIN_CYC, 500: minimum trigger high time in clk cycles (10 us @ 50 MHz) for a valid request.
- BURST_CYC, 10000: delay from trigger falling edge to echo rise (emulated 8-pulse burst, 200 us).
- TICK_DIV, 1: clk cycles per width tick; echo width = width_latched * TICK_DIV.
- TIMEOUT_CYC, 1900000: echo width for "no obstacle" (38 ms); also the saturation ceiling.
- HOLDOFF_CYC, 500000: dead time after echo falls; triggers are ignored during it.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- d_in  input  32  bus write data
- cs  input  1  chip select
- addr  input  5  register byte address
- rd  input  1  read strobe
- wr  input  1  write strobe
- d_out  output  32  read data; combinational; 0 unless cs&&rd
- trigger  input  1  asynchronous trigger from the sensor controller
- echo  output  1  emulated echo pulse, registered

Behaviour:
- Registers:
  - 0x00 WIDTH, RW [15:0], reset 16'h5A00.
  - 0x04 CONTROL, RW: bit0 enable (reset 1), bit1 no_echo (reset 0).
  - 0x08 STATUS, RO: [2:0] state code, [15:8] reject_cnt, [31:16] meas_cnt.
  - 0x0C LAST_TRIG, RO [31:0]: length in cycles of the last trigger pulse, saturating.
  - Unmapped reads return 0; writes to RO or unmapped addresses are ignored.
- trigger passes through a 2-FF synchronizer (trig_s); all timing below is referenced to trig_s.
- State machine: IDLE(0), TRIG_HI(1), BURST(2), ECHO(3), HOLDOFF(4). Reset: IDLE, echo=0, counters=0, LAST_TRIG=0.
- IDLE: trig_s high -> TRIG_HI with cnt=1.
- TRIG_HI: cnt increments while trig_s is high. On the first low sample, LAST_TRIG<=cnt, then:
  - cnt>=TRIG_MIN_CYC -> BURST, and WIDTH is latched into width_latched;
  - otherwise -> IDLE and reject_cnt increments, saturating at 255.
- BURST: after exactly BURST_CYC cycles in state, -> ECHO and echo<=1.
- ECHO: echo stays high for exactly N consecutive cycles, then echo<=0, -> HOLDOFF, and meas_cnt increments (wraps at 16 bits).
  - N = TIMEOUT_CYC if width_latched==0 or no_echo==1.
  - Otherwise N = min(width_latched*TICK_DIV, TIMEOUT_CYC), computed in 32-bit arithmetic.
- HOLDOFF: HOLDOFF_CYC cycles, then -> IDLE. Triggers arriving during HOLDOFF are ignored and not counted as rejects.
- A trigger asserted during BURST or ECHO is ignored.
- A WIDTH write during BURST/ECHO does not affect the current pulse; it applies from the next accepted trigger.
- enable=0: next cycle state<=IDLE and echo<=0, aborting any measurement with no meas_cnt increment; triggers are ignored while disabled. Counters are held, not cleared.
- Writing CONTROL with bit0=1 re-enables; the FSM starts from IDLE.
- rst in any state: immediate return to reset values on the next clock edge.

Optional Feature:
- HC_SR04_EMU_NOISE_EN: adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) that steps once per accepted trigger. Its low 3 bits are added to width_latched as 0..7 ticks of jitter before the N computation; saturation still applies.
- Without the macro, N is exact and no LFSR exists.

Test Plan (TRIG_MIN_CYC=10, BURST_CYC=20, TICK_DIV=4, TIMEOUT_CYC=1000, HOLDOFF_CYC=50):
- Write WIDTH=25, pulse trigger 12 cycles -> echo rises 20 cycles after TRIG_HI exits, stays high exactly 100 cycles; meas_cnt=1; LAST_TRIG=12.
- Trigger 5 cycles -> no echo; reject_cnt=1; state IDLE; LAST_TRIG=5.
- WIDTH=0, valid trigger -> echo high 1000 cycles. WIDTH=16'hFFFF -> echo saturates at 1000 cycles.
- Valid trigger, then second trigger during ECHO and third during HOLDOFF -> single echo; meas_cnt=1, reject_cnt=0.
- Write CONTROL=0 mid-ECHO -> echo low next cycle, STATUS state=0, meas_cnt unchanged. Re-enable and valid trigger -> normal 100-cycle echo.
- Write WIDTH=50 during BURST of a WIDTH=25 measurement -> current echo 100 cycles, next echo 200 cycles.
